alu_reservation_station: RTL and testbench

- Out-of-order issue buffer sitting between the decoder/dispatch stage and the ALU; initiator side of the ALU request interface (work_en, rob_id, opcode, rs1, rs2, imm, pc).
- Holds up to RS_SIZE pending ALU-class instructions.
- Snoops the ALU and LSB result broadcasts to resolve operand tags, then issues one ready instruction per cycle to the ALU.

---
 rtl/alu_reservation_station_pkg.sv | 22 ++
 rtl/alu_reservation_station_rs_pick.sv | 18 +
 rtl/alu_reservation_station.sv | 151 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: opcode codes and default geometry.
package alu_reservation_station_pkg;

  localparam int RS_SIZE_DEF = 8;
  localparam int ROB_W_DEF   = 4;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_SLT  = 6'd8;
  localparam logic [5:0] OP_ADDI = 6'd16;
  localparam logic [5:0] OP_ANDI = 6'd17;
  localparam logic [5:0] OP_ORI  = 6'd18;
  localparam logic [5:0] OP_LUI  = 6'd24;
  localparam logic [5:0] OP_BEQ  = 6'd32;
  localparam logic [5:0] OP_BNE  = 6'd33;

endpackage

// File: rtl/alu_reservation_station_rs_pick.sv
// Priority picker: reports whether any request bit is set and the index of the lowest one.
module rs_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[i]) o_idx = IW'(i);
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Out-of-order ALU issue buffer: holds dispatched ops, snoops both CDBs for operand
// tags and sends the lowest-index ready entry to the ALU each enabled cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             disp_en,
  input  logic [5:0]       disp_opcode,
  input  logic [ROB_W-1:0] disp_rob_id,
  input  logic [31:0]      disp_vj,
  input  logic             disp_has_qj,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_has_qk,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  output logic             rs_full,
  input  logic             alu_cdb_en,
  input  logic [ROB_W-1:0] alu_cdb_rob_id,
  input  logic [31:0]      alu_cdb_res,
  input  logic             lsb_cdb_en,
  input  logic [ROB_W-1:0] lsb_cdb_rob_id,
  input  logic [31:0]      lsb_cdb_res,
  output logic             work_en,
  output logic [ROB_W-1:0] rob_id,
  output logic [5:0]       opcode,
  output logic [31:0]      rs1,
  output logic [31:0]      rs2,
  output logic [31:0]      imm,
  output logic [31:0]      pc
);

  localparam int IW = $clog2(RS_SIZE);

  typedef struct packed {
    logic [5:0]       opcode;
    logic [ROB_W-1:0] rob_id;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             has_qj;
    logic [ROB_W-1:0] qj;
    logic             has_qk;
    logic [ROB_W-1:0] qk;
    logic [31:0]      imm;
    logic [31:0]      pc;
  } rs_ent_t;

  typedef struct packed {
    logic        has;
    logic [31:0] val;
  } opnd_t;

  logic [RS_SIZE-1:0] r_busy;
  rs_ent_t            r_ent [RS_SIZE];

  rs_ent_t            w_wk  [RS_SIZE];
  rs_ent_t            w_new;
  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_found, w_iss_found;
  logic [IW-1:0]      w_free_idx, w_iss_idx;

  // ALU broadcast wins if both ports carry the same tag.
  function automatic opnd_t snoop(input logic has_q, input logic [ROB_W-1:0] q,
                                  input logic [31:0] v);
    opnd_t o;
    o = '{has: has_q, val: v};
    if (has_q && alu_cdb_en && alu_cdb_rob_id == q)      o = '{has: 1'b0, val: alu_cdb_res};
    else if (has_q && lsb_cdb_en && lsb_cdb_rob_id == q) o = '{has: 1'b0, val: lsb_cdb_res};
    return o;
  endfunction

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_rdy
    assign w_ready[g] = r_busy[g] && !r_ent[g].has_qj && !r_ent[g].has_qk;
  end

  rs_pick #(.N(RS_SIZE)) u_free_pick (
    .i_req   (~r_busy),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_pick #(.N(RS_SIZE)) u_iss_pick (
    .i_req   (w_ready),
    .o_found (w_iss_found),
    .o_idx   (w_iss_idx)
  );

  assign rs_full = !w_free_found;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_wk[i] = r_ent[i];
      if (r_busy[i]) begin
        {w_wk[i].has_qj, w_wk[i].vj} = snoop(r_ent[i].has_qj, r_ent[i].qj, r_ent[i].vj);
        {w_wk[i].has_qk, w_wk[i].vk} = snoop(r_ent[i].has_qk, r_ent[i].qk, r_ent[i].vk);
      end
    end
    w_new.opcode = disp_opcode;
    w_new.rob_id = disp_rob_id;
    w_new.qj     = disp_qj;
    w_new.qk     = disp_qk;
    w_new.imm    = disp_imm;
    w_new.pc     = disp_pc;
    {w_new.has_qj, w_new.vj} = snoop(disp_has_qj, disp_qj, disp_vj);
    {w_new.has_qk, w_new.vk} = snoop(disp_has_qk, disp_qk, disp_vk);
  end

  // The free slot is never busy and the issue slot always is, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= '0;
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      work_en <= 1'b0;
      rob_id  <= '0;
      opcode  <= '0;
      rs1     <= '0;
      rs2     <= '0;
      imm     <= '0;
      pc      <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_busy  <= '0;
        work_en <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= w_wk[i];
        work_en <= w_iss_found;
        if (w_iss_found) begin
          rob_id            <= r_ent[w_iss_idx].rob_id;
          opcode            <= r_ent[w_iss_idx].opcode;
          rs1               <= r_ent[w_iss_idx].vj;
          rs2               <= r_ent[w_iss_idx].vk;
          imm               <= r_ent[w_iss_idx].imm;
          pc                <= r_ent[w_iss_idx].pc;
          r_busy[w_iss_idx] <= 1'b0;
        end
        if (disp_en && w_free_found) begin
          r_ent[w_free_idx]  <= w_new;
          r_busy[w_free_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed plus random stimulus against a slot-level reference model of the reservation station.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, disp_en;
  logic [5:0]  disp_opcode;
  logic [3:0]  disp_rob_id, disp_qj, disp_qk;
  logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
  logic        disp_has_qj, disp_has_qk;
  logic        rs_full;
  logic        alu_cdb_en, lsb_cdb_en;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_res, lsb_cdb_res;
  logic        work_en;
  logic [3:0]  rob_id;
  logic [5:0]  opcode;
  logic [31:0] rs1, rs2, imm, pc;

  always #5 clk = ~clk;

  alu_reservation_station #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_rob_id(disp_rob_id),
    .disp_vj(disp_vj), .disp_has_qj(disp_has_qj), .disp_qj(disp_qj),
    .disp_vk(disp_vk), .disp_has_qk(disp_has_qk), .disp_qk(disp_qk),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .rs_full(rs_full),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_res(alu_cdb_res),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_res(lsb_cdb_res),
    .work_en(work_en), .rob_id(rob_id), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc)
  );

  // Reference model: one record per slot, plus the last request sent to the ALU.
  typedef struct packed {
    bit        busy;
    bit [5:0]  op;
    bit [3:0]  rid;
    bit [31:0] vj, vk;
    bit        hj, hk;
    bit [3:0]  qj, qk;
    bit [31:0] imm, pc;
  } ment_t;

  ment_t     m [N];
  bit        m_we;
  bit [3:0]  m_rid;
  bit [5:0]  m_op;
  bit [31:0] m_rs1, m_rs2, m_imm, m_pc;
  int        n_cmp = 0, n_err = 0, n_proto = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Operand value after looking at this cycle's broadcasts: {still_pending, value}.
  function automatic bit [32:0] resolve(bit h, bit [3:0] q, bit [31:0] v);
    if (!h) return {1'b0, v};
    if (alu_cdb_en && alu_cdb_rob_id == q) return {1'b0, alu_cdb_res};
    if (lsb_cdb_en && lsb_cdb_rob_id == q) return {1'b0, lsb_cdb_res};
    return {1'b1, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '0;
    m_we = 0; m_rid = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    ment_t nx [N];
    int    iss = -1, fr = -1;
    if (!rst) begin model_reset(); return; end
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_we = 0;
      return;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i].busy && !m[i].hj && !m[i].hk) iss = i;
      if (!m[i].busy) fr = i;
    end
    nx = m;
    for (int i = 0; i < N; i++) if (m[i].busy) begin
      {nx[i].hj, nx[i].vj} = resolve(m[i].hj, m[i].qj, m[i].vj);
      {nx[i].hk, nx[i].vk} = resolve(m[i].hk, m[i].qk, m[i].vk);
    end
    m_we = (iss >= 0);
    if (iss >= 0) begin
      m_rid = m[iss].rid; m_op = m[iss].op; m_rs1 = m[iss].vj; m_rs2 = m[iss].vk;
      m_imm = m[iss].imm; m_pc = m[iss].pc;
      nx[iss].busy = 0;
    end
    if (disp_en) begin
      if (fr < 0) n_proto++;
      else begin
        nx[fr].busy = 1; nx[fr].op = disp_opcode; nx[fr].rid = disp_rob_id;
        nx[fr].qj = disp_qj; nx[fr].qk = disp_qk; nx[fr].imm = disp_imm; nx[fr].pc = disp_pc;
        {nx[fr].hj, nx[fr].vj} = resolve(disp_has_qj, disp_qj, disp_vj);
        {nx[fr].hk, nx[fr].vk} = resolve(disp_has_qk, disp_qk, disp_vk);
      end
    end
    m = nx;
  endtask

  task automatic check_all();
    chk("work_en", 32'(work_en), 32'(m_we));
    chk("rs_full", 32'(rs_full), 32'(m_full()));
    chk("rob_id",  32'(rob_id),  32'(m_rid));
    chk("opcode",  32'(opcode),  32'(m_op));
    chk("rs1", rs1, m_rs1);
    chk("rs2", rs2, m_rs2);
    chk("imm", imm, m_imm);
    chk("pc",  pc,  m_pc);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    disp_en = 0; flush = 0; alu_cdb_en = 0; lsb_cdb_en = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] rid,
                      input logic [31:0] vj, input logic hj, input logic [3:0] qj,
                      input logic [31:0] vk, input logic hk, input logic [3:0] qk,
                      input logic [31:0] im, input logic [31:0] p);
    disp_en = 1; disp_opcode = op; disp_rob_id = rid;
    disp_vj = vj; disp_has_qj = hj; disp_qj = qj;
    disp_vk = vk; disp_has_qk = hk; disp_qk = qk;
    disp_imm = im; disp_pc = p;
  endtask

  initial begin
    rst = 0; rdy = 1; idle();
    disp_opcode = 0; disp_rob_id = 0; disp_vj = 0; disp_has_qj = 0; disp_qj = 0;
    disp_vk = 0; disp_has_qk = 0; disp_qk = 0; disp_imm = 0; disp_pc = 0;
    alu_cdb_rob_id = 0; alu_cdb_res = 0; lsb_cdb_rob_id = 0; lsb_cdb_res = 0;
    model_reset();
    #2;
    chk("rst_work_en", 32'(work_en), 32'd0);
    chk("rst_rs_full", 32'(rs_full), 32'd0);
    chk("rst_rob_id", 32'(rob_id), 32'd0);
    chk("rst_rs1", rs1, 32'd0);
    chk("rst_pc", pc, 32'd0);
    tick(); tick();
    rst = 1;
    tick();

    // Simple ADDI: issue two edges after dispatch, exactly one pulse.
    disp(OP_ADDI, 4'd1, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd7, 32'h100);
    tick(); idle();
    chk("addi_early", 32'(work_en), 32'd0);
    tick();
    chk("addi_we", 32'(work_en), 32'd1);
    chk("addi_rs1", rs1, 32'd5);
    chk("addi_imm", imm, 32'd7);
    chk("addi_rob", 32'(rob_id), 32'd1);
    tick();
    chk("addi_pulse", 32'(work_en), 32'd0);

    // Dependency wakeup through the ALU broadcast.
    disp(OP_ADD, 4'd2, 32'd0, 1'b1, 4'd3, 32'd9, 1'b0, 4'd0, 32'd0, 32'h104);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dep_wait", 32'(work_en), 32'd0);
    end
    alu_cdb_en = 1; alu_cdb_rob_id = 4'd3; alu_cdb_res = 32'h10;
    tick(); idle();
    chk("dep_no_early", 32'(work_en), 32'd0);
    tick();
    chk("dep_we", 32'(work_en), 32'd1);
    chk("dep_rs1", rs1, 32'h10);
    tick();

    // Dispatch-time bypass from the LSB broadcast.
    disp(OP_SUB, 4'd4, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'd0, 32'h108);
    lsb_cdb_en = 1; lsb_cdb_rob_id = 4'd2; lsb_cdb_res = 32'hAB;
    tick(); idle();
    tick();
    chk("byp_we", 32'(work_en), 32'd1);
    chk("byp_rs2", rs2, 32'hAB);
    tick();

    // Fill all slots waiting on tag 9; overflow dispatch is dropped; wake drains in index order.
    for (int i = 0; i < N; i++) begin
      disp(OP_XOR, 4'(i), 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 32'(i * 3), 32'(i * 4));
      tick();
    end
    chk("full_set", 32'(rs_full), 32'd1);
    disp(OP_OR, 4'd10, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick(); idle();
    alu_cdb_en = 1; alu_cdb_rob_id = 4'd9; alu_cdb_res = 32'h99;
    tick(); idle();
    for (int i = 0; i < N; i++) begin
      tick();
      chk("order_we", 32'(work_en), 32'd1);
      chk("order_rob", 32'(rob_id), 32'(i));
      if (i == 0) chk("full_drop", 32'(rs_full), 32'd0);
    end
    tick();
    chk("drain_we", 32'(work_en), 32'd0);

    // Flush with ready entries pending; same-cycle dispatch is discarded.
    for (int i = 0; i < 4; i++) begin
      disp(OP_AND, 4'(i + 1), 32'd0, 1'b1, 4'd5, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
      tick();
    end
    idle();
    alu_cdb_en = 1; alu_cdb_rob_id = 4'd5; alu_cdb_res = 32'h55;
    tick(); idle();
    flush = 1;
    disp(OP_ADD, 4'd7, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick(); idle();
    chk("flush_we", 32'(work_en), 32'd0);
    chk("flush_full", 32'(rs_full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_quiet", 32'(work_en), 32'd0);
    end

    // Asynchronous reset between edges while an issue pulse is live.
    disp(OP_ADD, 4'd11, 32'd0, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0); tick();
    disp(OP_ADD, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd0, 32'd0); tick();
    disp(OP_ADD, 4'd13, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd0, 32'd0); tick();
    idle();
    tick();
    chk("pre_rst_we", 32'(work_en), 32'd1);
    rst = 0;
    #1;
    model_reset();
    chk("arst_we", 32'(work_en), 32'd0);
    chk("arst_full", 32'(rs_full), 32'd0);
    chk("arst_rob", 32'(rob_id), 32'd0);
    tick();
    rst = 1;
    alu_cdb_en = 1; alu_cdb_rob_id = 4'd6; alu_cdb_res = 32'h66;
    tick(); idle();
    tick();
    chk("post_rst_we", 32'(work_en), 32'd0);

    // rdy low freezes everything, including a live work_en.
    disp(OP_ADDI, 4'd14, 32'd8, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1, 32'h200);
    tick(); idle();
    tick();
    rdy = 0;
    disp(OP_ADDI, 4'd15, 32'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd2, 32'h204);
    tick();
    chk("rdy_hold_we", 32'(work_en), 32'd1);
    idle(); rdy = 1;
    tick(); tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rdy   = ($urandom_range(9) != 0);
      flush = ($urandom_range(39) == 0);
      if ($urandom_range(1) == 1)
        disp(6'($urandom_range(63)), 4'($urandom_range(15)),
             $urandom, 1'($urandom_range(1)), 4'($urandom_range(15)),
             $urandom, 1'($urandom_range(1)), 4'($urandom_range(15)),
             $urandom, $urandom);
      else disp_en = 0;
      alu_cdb_en = ($urandom_range(1) == 1);
      alu_cdb_rob_id = 4'($urandom_range(15)); alu_cdb_res = $urandom;
      lsb_cdb_en = ($urandom_range(1) == 1);
      lsb_cdb_rob_id = 4'($urandom_range(15)); lsb_cdb_res = $urandom;
      if (alu_cdb_en && lsb_cdb_en && alu_cdb_rob_id == lsb_cdb_rob_id)
        lsb_cdb_rob_id = lsb_cdb_rob_id ^ 4'd1;
      tick();
    end
    idle(); rdy = 1;
    tick();

    $display("note: %0d dispatches attempted while full", n_proto);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
